muldiv_unit: RTL and testbench

//  Parametrised iterative RV32M/RV64M multiply/divide unit beside the single-cycle ALU in the execute stage.

---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_unit.sv | 108 ++++++++++
 tb/tb_muldiv_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake bundle for muldiv_unit
interface muldiv_if #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5
);
  logic in_valid;
  logic in_ready;
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic illegal;
  logic busy;
  modport master (
    output in_valid, opcode, funct7, funct, op_a, op_b, in_tag, out_ready,
    input in_ready, out_valid, result, out_tag, illegal, busy
  );
  modport slave (
    input in_valid, opcode, funct7, funct, op_a, op_b, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, illegal, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide; define MULDIV_FAST_MUL_EN for a registered single-cycle multiply
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5
) (
  input logic clk,
  input logic rst,
  input logic kill,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_next_state;
  logic [2*XLEN-1:0] r_p;
  logic [XLEN-1:0] r_d, r_res;
  logic [CW-1:0] r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic r_div, r_hi, r_neg, r_illegal;
  logic w_in_ready, w_busy, w_out_valid, w_accept, w_last;
  logic w_illegal, w_sa, w_sb, w_neg, w_hi, w_dz, w_ovf, w_fast, w_special;
  logic [2:0] w_f;
  logic [XLEN-1:0] w_a, w_b, w_ma, w_mb, w_fres, w_sres, w_draw, w_fix;
  logic [XLEN:0] w_add, w_sub;
  logic [2*XLEN-1:0] w_step, w_pn;
  assign w_f = bus.funct;
  assign w_a = bus.op_a;
  assign w_b = bus.op_b;
  assign w_illegal = (bus.opcode != OPC_ARI_RTYPE) || (bus.funct7 != 7'b0000001);
  assign w_sa = w_a[XLEN-1] & ((w_f == 3'b001) | (w_f == 3'b010) | (w_f[2] & ~w_f[0]));
  assign w_sb = w_b[XLEN-1] & ((w_f == 3'b001) | (w_f[2] & ~w_f[0]));
  assign w_hi = w_f[2] ? w_f[1] : |w_f[1:0];
  assign w_neg = (w_f[2] & w_f[1]) ? w_sa : w_sa ^ w_sb;
  assign w_ma = w_sa ? -w_a : w_a;
  assign w_mb = w_sb ? -w_b : w_b;
  assign w_dz = w_f[2] & ~|w_b;
  assign w_ovf = w_f[2] & ~w_f[0] & (w_a == {1'b1, {(XLEN-1){1'b0}}}) & (&w_b);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fm, w_fp;
  assign w_fm = {{XLEN{1'b0}}, w_ma} * {{XLEN{1'b0}}, w_mb};
  assign w_fp = w_neg ? -w_fm : w_fm;
  assign w_fast = ~w_f[2];
  assign w_fres = w_hi ? w_fp[2*XLEN-1:XLEN] : w_fp[XLEN-1:0];
`else
  assign w_fast = 1'b0;
  assign w_fres = '0;
`endif
  assign w_special = w_illegal | w_dz | w_ovf | w_fast;
  assign w_sres = w_illegal ? '0 : w_dz ? (w_f[1] ? w_a : '1) : w_ovf ? (w_f[1] ? '0 : w_a) : w_fres;
  assign w_accept = bus.in_valid & w_in_ready & ~kill;
  assign w_last = (r_state == S_CALC) && (r_cnt == LAST);
  assign w_add = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_d} : '0);
  assign w_sub = r_p[2*XLEN-1:XLEN-1] - {1'b0, r_d};
  assign w_step = r_div ? (w_sub[XLEN] ? {r_p[2*XLEN-2:0], 1'b0} : {w_sub[XLEN-1:0], r_p[XLEN-2:0], 1'b1})
                        : {w_add, r_p[XLEN-1:1]};
  assign w_pn = r_neg ? -w_step : w_step;
  assign w_draw = r_hi ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
  assign w_fix = r_div ? (r_neg ? -w_draw : w_draw) : (r_hi ? w_pn[2*XLEN-1:XLEN] : w_pn[XLEN-1:0]);
  always_ff @(posedge clk)
    r_state <= rst ? S_IDLE : w_next_state;
  always_comb begin
    w_next_state = kill ? S_IDLE :
                   (r_state == S_IDLE) ? (w_accept ? (w_special ? S_DONE : S_CALC) : S_IDLE) :
                   (r_state == S_CALC) ? (w_last ? S_DONE : S_CALC) :
                   (bus.out_ready ? S_IDLE : S_DONE);
  end
  always_comb begin
    w_in_ready = (r_state == S_IDLE) && !rst;
    w_busy = r_state != S_IDLE;
    w_out_valid = r_state == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p <= '0;
      r_d <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_tag <= '0;
      r_div <= 1'b0;
      r_hi <= 1'b0;
      r_neg <= 1'b0;
      r_illegal <= 1'b0;
    end else if (kill) begin
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_p <= {{XLEN{1'b0}}, w_ma};
      r_d <= w_mb;
      r_cnt <= '0;
      r_tag <= bus.in_tag;
      r_div <= w_f[2];
      r_hi <= w_hi;
      r_neg <= w_neg;
      r_illegal <= w_illegal;
      if (w_special) r_res <= w_sres;
    end else if (r_state == S_CALC) begin
      r_p <= w_step;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_res <= w_fix;
    end
  end
  assign bus.in_ready = w_in_ready;
  assign bus.busy = w_busy;
  assign bus.out_valid = w_out_valid;
  assign bus.result = r_res;
  assign bus.out_tag = r_tag;
  assign bus.illegal = r_illegal;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int TAG_W = 5;
  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] F7M = 7'b0000001;
  localparam logic [31:0] MIN = 32'h80000000;
  localparam logic [31:0] ONES = 32'hFFFFFFFF;
  logic clk = 1'b0;
  logic rst, kill;
  int n_asrt = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .kill(kill), .bus(bus.slave));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ovf = (a == MIN) && (b == ONES);
    case (f)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin p = sa / ((b == 0) ? 1 : sb); return (b == 0) ? ONES : ovf ? a : p[31:0]; end
      3'd5: return (b == 0) ? ONES : a / b;
      3'd6: begin p = sa % ((b == 0) ? 1 : sb); return (b == 0) ? a : ovf ? 32'd0 : p[31:0]; end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return ONES;
      2: return MIN;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic start(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.opcode = opc;
    bus.funct7 = f7;
    bus.funct = f;
    bus.op_a = a;
    bus.op_b = b;
    bus.in_tag = tag;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic issue(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    logic ill;
    logic [31:0] exp;
    int lat, n;
    ill = (opc != OPC) || (f7 != F7M);
    exp = ill ? 32'd0 : ref_op(f, a, b);
    lat = (ill || (f[2] && (b == 0 || (!f[0] && a == MIN && b == ONES)))) ? 1 : XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) lat = 1;
`endif
    chk("in_ready_idle", bus.in_ready, 1);
    start(opc, f7, f, a, b, tag);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency f%0d", f), n, lat);
    chk($sformatf("result f%0d a=%0h b=%0h", f, a, b), bus.result, exp);
    chk("out_tag", bus.out_tag, tag);
    chk("illegal", bus.illegal, ill);
  endtask
  task automatic run(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    issue(opc, f7, f, a, b, tag);
    @(posedge clk); #1;
    chk("out_valid_after_consume", bus.out_valid, 0);
  endtask
  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation time limit reached");
  end
  initial begin
    logic seen;
    rst = 1'b1;
    kill = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.opcode = OPC;
    bus.funct7 = F7M;
    bus.funct = 3'd0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready_released", bus.in_ready, 1);
    run(OPC, F7M, 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    run(OPC, F7M, 3'd3, ONES, ONES, 5'd1);
    run(OPC, F7M, 3'd2, ONES, 32'd2, 5'd2);
    run(OPC, F7M, 3'd1, ONES, 32'd2, 5'd3);
    run(OPC, F7M, 3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
    run(OPC, F7M, 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
    run(OPC, F7M, 3'd5, 32'd5, 32'd0, 5'd7);
    run(OPC, F7M, 3'd7, 32'd5, 32'd0, 5'd8);
    run(OPC, F7M, 3'd4, MIN, ONES, 5'd9);
    run(OPC, F7M, 3'd6, MIN, ONES, 5'd10);
    run(OPC, 7'b0100000, 3'd0, 32'd3, 32'd4, 5'd11);
    run(7'b0010011, F7M, 3'd4, 32'd9, 32'd0, 5'd12);
    run(OPC, F7M, 3'd0, 32'd7, 32'd6, 5'd13);
    bus.out_ready = 1'b0;
    issue(OPC, F7M, 3'd4, 32'hFFFFFFF9, 32'd2, 5'd14);
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_result", bus.result, 32'hFFFFFFFD);
      chk("hold_out_tag", bus.out_tag, 14);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    start(OPC, F7M, 3'd5, 32'd100, 32'd0, 5'd15);
    chk("no_accept_in_done_valid", bus.out_valid, 0);
    chk("no_accept_in_done_busy", bus.busy, 0);
    start(OPC, F7M, 3'd0, 32'd123, 32'd456, 5'd16);
    repeat (11) begin @(posedge clk); #1; end
    chk("calc_busy_before_kill", bus.busy, 1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", bus.busy, 0);
    chk("kill_in_ready", bus.in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    chk("kill_no_out_valid", seen, 0);
    kill = 1'b1;
    start(OPC, F7M, 3'd4, 32'd8, 32'd0, 5'd17);
    kill = 1'b0;
    chk("kill_beats_accept", bus.busy, 0);
    bus.out_ready = 1'b0;
    issue(7'b0000000, F7M, 3'd0, 32'd1, 32'd1, 5'd18);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_done_out_valid", bus.out_valid, 0);
    chk("kill_done_illegal", bus.illegal, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      run(($urandom_range(0, 9) == 0) ? 7'b0010011 : OPC, F7M, 3'($urandom_range(0, 7)),
          pick(), pick(), 5'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
